// File: rtl/way_alloc_ctrl.sv
// rtl/way_alloc_ctrl.sv - 4-way tree-PLRU victim allocator with writeback/refill sequencing
// Optional feature macro: WAY_ALLOC_STATS_EN adds the 16-bit evict_cnt output.
module way_alloc_ctrl #(
  parameter int NUM_SETS = 64,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_valid,
  input  logic [SET_W-1:0] hit_set,
  input  logic [1:0]       hit_way,
  input  logic             alloc_req,
  input  logic [SET_W-1:0] alloc_set,
  input  logic [3:0]       valid_mask,
  input  logic [3:0]       dirty_mask,
  output logic             alloc_ready,
  output logic             wb_req,
  input  logic             wb_ack,
  output logic             fill_req,
  input  logic             fill_done,
  output logic [1:0]       alloc_way,
`ifdef WAY_ALLOC_STATS_EN
  output logic [15:0]      evict_cnt,
`endif
  output logic             alloc_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_WB     = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q;
  logic [3:0]       valid_q;
  logic [3:0]       dirty_q;
  logic [1:0]       alloc_way_q;
  logic [1:0]       victim;
  logic [2:0]       cur_plru;
  logic [2:0]       plru_q [NUM_SETS];
  logic [2:0]       plru_d [NUM_SETS];

  // Entry bits are {root, left, right}; an access steers the tree away from the touched way.
  function automatic logic [2:0] plru_touch(input logic [2:0] cur, input logic [1:0] way);
    logic [2:0] nxt;
    case (way)
      2'd0:    nxt = {1'b0, 1'b0, cur[0]};
      2'd1:    nxt = {1'b0, 1'b1, cur[0]};
      2'd2:    nxt = {1'b1, cur[1], 1'b0};
      default: nxt = {1'b1, cur[1], 1'b1};
    endcase
    return nxt;
  endfunction

  // Victim choice from the latched masks and the current PLRU entry of the latched set.
  always_comb begin
    victim   = 2'd0;
    cur_plru = plru_q[set_q];
    if (!valid_q[0])      victim = 2'd0;
    else if (!valid_q[1]) victim = 2'd1;
    else if (!valid_q[2]) victim = 2'd2;
    else if (!valid_q[3]) victim = 2'd3;
    else if (!cur_plru[2]) victim = cur_plru[0] ? 2'd2 : 2'd3;
    else                   victim = cur_plru[1] ? 2'd0 : 2'd1;
  end

  // Next-state and outputs; wb_ack/fill_done only matter in their own states.
  always_comb begin
    state_d     = state_q;
    alloc_ready = 1'b0;
    wb_req      = 1'b0;
    fill_req    = 1'b0;
    alloc_done  = 1'b0;
    alloc_way   = 2'd0;
    case (state_q)
      S_IDLE: begin
        alloc_ready = 1'b1;
        if (alloc_req) state_d = S_SELECT;
      end
      S_SELECT: begin
        alloc_way = victim;
        state_d   = (valid_q[victim] && dirty_q[victim]) ? S_WB : S_FILL;
      end
      S_WB: begin
        wb_req    = 1'b1;
        alloc_way = alloc_way_q;
        if (wb_ack) state_d = S_FILL;
      end
      S_FILL: begin
        fill_req  = 1'b1;
        alloc_way = alloc_way_q;
        if (fill_done) state_d = S_DONE;
      end
      S_DONE: begin
        alloc_done = 1'b1;
        alloc_way  = alloc_way_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PLRU next state: the completing allocation's update overrides a hit to the same set.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      plru_d[s] = plru_q[s];
      if (state_q == S_DONE && set_q == SET_W'(s))
        plru_d[s] = plru_touch(plru_q[s], alloc_way_q);
      else if (hit_valid && hit_set == SET_W'(s))
        plru_d[s] = plru_touch(plru_q[s], hit_way);
    end
  end

  // PLRU storage, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= 3'd0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= plru_d[s];
    end
  end

  // FSM state plus the request fields captured on accept and the victim captured in SELECT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      set_q       <= '0;
      valid_q     <= 4'd0;
      dirty_q     <= 4'd0;
      alloc_way_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && alloc_req) begin
        set_q   <= alloc_set;
        valid_q <= valid_mask;
        dirty_q <= dirty_mask;
      end
      if (state_q == S_SELECT) alloc_way_q <= victim;
    end
  end

`ifdef WAY_ALLOC_STATS_EN
  logic [15:0] evict_cnt_q;

  // Count entries into writeback, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_cnt_q <= 16'd0;
    end else if (state_q == S_SELECT && state_d == S_WB && evict_cnt_q != 16'hFFFF) begin
      evict_cnt_q <= evict_cnt_q + 16'd1;
    end
  end

  assign evict_cnt = evict_cnt_q;
`endif

endmodule
